// File: rtl/miv_ram_scrub_pkg.sv
// Shared types and geometry for the ECC TCM scrub controller.
package miv_ram_scrub_pkg;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int RAM_DEPTH = 2048;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCRUB_RD  = 2'd1,
    SCRUB_CHK = 2'd2,
    SCRUB_WB  = 2'd3
  } scrub_state_e;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] raddr;
  } ram_req_t;

endpackage

// File: rtl/miv_sat_counter.sv
// Saturating event counter; a clear coinciding with an event leaves the count at 1.
module miv_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = CNT_W'(inc);
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/miv_ram_scrub_ctrl.sv
// Host/scrubber arbiter in front of the 2048x32 ECC TCM, with SB/DB statistics
// and a double-bit interrupt.
module miv_ram_scrub_ctrl
  import miv_ram_scrub_pkg::*;
#(
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              scrub_en,
  input  logic              cnt_clr,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_sb,
  output logic              host_db,
  output logic [DATA_W-1:0] ram_wd,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rd,
  input  logic              ram_sb,
  input  logic              ram_db,
  output logic [CNT_W-1:0]  sb_cnt,
  output logic [CNT_W-1:0]  db_cnt,
  output logic [ADDR_W-1:0] db_addr,
  output logic              db_irq,
  output logic              scrub_pass
);

  localparam logic [15:0] IVL_RELOAD = 16'(SCRUB_INTERVAL - 1);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;
  logic              pend_q, pend_d;
  logic [15:0]       ivl_q, ivl_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_cancel_q, wb_cancel_d;
  logic              rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] db_addr_q, db_addr_d;
  logic              db_irq_q, db_irq_d;
  logic              pass_q, pass_d;

  logic     scrub_go, rd_valid, sb_evt, db_evt;
  ram_req_t ram_req;

  // A pending scrub only launches from IDLE on a cycle the host leaves free.
  assign scrub_go = (state_q == IDLE) & scrub_en & (pend_q | (ivl_q == '0)) & ~host_req;

  always_comb begin
    host_gnt = RESETN & host_req & (state_q != SCRUB_RD) & (state_q != SCRUB_WB);
    ram_req  = '0;
    case (state_q)
      SCRUB_RD: ram_req.raddr = scrub_addr_q;
      SCRUB_WB: begin
        if (!wb_cancel_q) begin
          ram_req.wen   = 1'b1;
          ram_req.waddr = wb_addr_q;
          ram_req.wd    = wb_data_q;
        end
      end
      default: ;
    endcase
    if (host_gnt) begin
      if (host_we) begin
        ram_req.wen   = 1'b1;
        ram_req.waddr = host_addr;
        ram_req.wd    = host_wdata;
      end else begin
        ram_req.raddr = host_addr;
      end
    end
  end

  assign ram_wen   = ram_req.wen;
  assign ram_waddr = ram_req.waddr;
  assign ram_wd    = ram_req.wd;
  assign ram_raddr = ram_req.raddr;

  // Interval timer only runs while idle; any launched scrub re-arms it.
  always_comb begin
    ivl_d  = ivl_q;
    pend_d = pend_q;
    if (!scrub_en || (state_q != IDLE) || scrub_go) begin
      ivl_d  = IVL_RELOAD;
      pend_d = 1'b0;
    end else if (ivl_q == '0) begin
      pend_d = 1'b1;
    end else begin
      ivl_d = ivl_q - 16'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    wb_cancel_d  = wb_cancel_q;
    pass_d       = 1'b0;
    case (state_q)
      IDLE:     if (scrub_go) state_d = SCRUB_RD;
      SCRUB_RD: state_d = SCRUB_CHK;
      SCRUB_CHK: begin
        scrub_addr_d = scrub_addr_q + ADDR_W'(1);
        pass_d       = &scrub_addr_q;
        wb_addr_d    = scrub_addr_q;
        wb_data_d    = ram_rd;
        // A host write landing on the word being scrubbed supersedes the fix-up.
        wb_cancel_d  = host_gnt & host_we & (host_addr == scrub_addr_q);
        state_d      = (ram_sb & ~ram_db) ? SCRUB_WB : IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // RAM output is already registered, so a read result is consumed the cycle it appears.
  assign rd_valid = rvalid_q | (state_q == SCRUB_CHK);
  assign sb_evt   = rd_valid & ram_sb;
  assign db_evt   = rd_valid & ram_db;

  always_comb begin
    rvalid_d  = host_gnt & ~host_we;
    rd_addr_d = ram_req.raddr;
    db_irq_d  = db_evt;
    db_addr_d = db_evt ? rd_addr_q : db_addr_q;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= IDLE;
      scrub_addr_q <= '0;
      pend_q       <= 1'b0;
      ivl_q        <= IVL_RELOAD;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wb_cancel_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      rd_addr_q    <= '0;
      db_addr_q    <= '0;
      db_irq_q     <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      pend_q       <= pend_d;
      ivl_q        <= ivl_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      wb_cancel_q  <= wb_cancel_d;
      rvalid_q     <= rvalid_d;
      rd_addr_q    <= rd_addr_d;
      db_addr_q    <= db_addr_d;
      db_irq_q     <= db_irq_d;
      pass_q       <= pass_d;
    end
  end

  assign host_rvalid = rvalid_q;
  assign host_rdata  = rvalid_q ? ram_rd : '0;
  assign host_sb     = rvalid_q & ram_sb;
  assign host_db     = rvalid_q & ram_db;
  assign db_addr     = db_addr_q;
  assign db_irq      = db_irq_q;
  assign scrub_pass  = pass_q;

  miv_sat_counter #(.CNT_W(CNT_W)) u_sb_cnt (
    .clk   (CLK),
    .rst_n (RESETN),
    .inc   (sb_evt),
    .clr   (cnt_clr),
    .cnt   (sb_cnt)
  );

  miv_sat_counter #(.CNT_W(CNT_W)) u_db_cnt (
    .clk   (CLK),
    .rst_n (RESETN),
    .inc   (db_evt),
    .clr   (cnt_clr),
    .cnt   (db_cnt)
  );

endmodule

// File: tb/tb_miv_ram_scrub_ctrl.sv
// Scoreboard bench for miv_ram_scrub_ctrl with a behavioural ECC RAM model.
module tb_miv_ram_scrub_ctrl;

  localparam int IVL = 4;
  localparam int CW  = 3;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          scrub_en, cnt_clr, host_req, host_we;
  logic [10:0]   host_addr;
  logic [31:0]   host_wdata;
  logic          host_gnt, host_rvalid, host_sb, host_db;
  logic [31:0]   host_rdata;
  logic [31:0]   ram_wd, ram_rd;
  logic [10:0]   ram_waddr, ram_raddr;
  logic          ram_wen, ram_sb, ram_db;
  logic [CW-1:0] sb_cnt, db_cnt;
  logic [10:0]   db_addr;
  logic          db_irq, scrub_pass;

  miv_ram_scrub_ctrl #(.SCRUB_INTERVAL(IVL), .CNT_W(CW)) dut (
    .CLK(CLK), .RESETN(RESETN), .scrub_en(scrub_en), .cnt_clr(cnt_clr),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_sb(host_sb), .host_db(host_db),
    .ram_wd(ram_wd), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_wen(ram_wen),
    .ram_rd(ram_rd), .ram_sb(ram_sb), .ram_db(ram_db),
    .sb_cnt(sb_cnt), .db_cnt(db_cnt), .db_addr(db_addr), .db_irq(db_irq),
    .scrub_pass(scrub_pass)
  );

  always #5 CLK = ~CLK;

  // RAM model: stores corrected data, flags per word, flags masked after any write.
  bit [31:0] mem    [2048];
  bit        sb_err [2048];
  bit        db_err [2048];
  int        wr_hits[2048];
  int        wr_total = 0;
  logic [31:0] wr_ld = '0;
  logic        inj_go = 1'b0, inj_s = 1'b0, inj_d = 1'b0;
  logic [10:0] inj_a = '0;
  int          cyc = 0;

  always @(posedge CLK) begin
    cyc    <= cyc + 1;
    ram_rd <= mem[ram_raddr];
    ram_sb <= ram_wen ? 1'b0 : sb_err[ram_raddr];
    ram_db <= ram_wen ? 1'b0 : db_err[ram_raddr];
    if (inj_go) begin
      sb_err[inj_a] <= inj_s;
      db_err[inj_a] <= inj_d;
    end
    if (ram_wen) begin
      mem[ram_waddr]     <= ram_wd;
      sb_err[ram_waddr]  <= 1'b0;
      db_err[ram_waddr]  <= 1'b0;
      wr_hits[ram_waddr] <= wr_hits[ram_waddr] + 1;
      wr_total           <= wr_total + 1;
      wr_ld              <= ram_wd;
    end
  end

  typedef struct {
    logic [31:0] d;
    logic        sb;
    logic        db;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_err = 0;
  int   irq_hi = 0, pass_hi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read result is presented.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge CLK);
      if (db_irq) irq_hi++;
      if (scrub_pass) pass_hi++;
      if (host_rvalid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 32'(host_rvalid), 32'(0));
        else begin
          e = exp_q.pop_front();
          chk("rd_data", host_rdata, e.d);
          chk("rd_sb", 32'(host_sb), 32'(e.sb));
          chk("rd_db", 32'(host_db), 32'(e.db));
          chk("rd_latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the grant cycle.
  task automatic host_op(input logic we, input logic [10:0] a, input logic [31:0] d,
                         input logic esb, input logic edb, output int stalls);
    exp_t e;
    logic got;
    got = 1'b0;
    stalls = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (host_gnt) got = 1'b1;
      else begin
        stalls++;
        @(negedge CLK);
      end
    end
    chk("gnt_timeout", 32'(got), 32'(1));
    if (got && !we) begin
      e.d = d; e.sb = esb; e.db = edb; e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    host_req = 1'b0;
  endtask

  task automatic inject(input logic [10:0] a, input logic s, input logic d);
    inj_a = a; inj_s = s; inj_d = d; inj_go = 1'b1;
    @(negedge CLK);
    inj_go = 1'b0;
  endtask

  task automatic wait_rd(input logic [10:0] a, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (ram_raddr == a && !host_req) break;
      @(negedge CLK);
    end
    chk("wait_scrub_rd", 32'(i < bound), 32'(1));
  endtask

  task automatic wait_hits(input logic [10:0] a, input int target, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (wr_hits[a] >= target) break;
      @(negedge CLK);
    end
    chk("wait_write", 32'(i < bound), 32'(1));
  endtask

  initial begin
    int st, sum, h, i;
    RESETN = 1'b0; scrub_en = 1'b0; cnt_clr = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h5A5; host_wdata = 32'h1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_gnt", 32'(host_gnt), 32'(0));
    chk("rst_wen", 32'(ram_wen), 32'(0));
    chk("rst_raddr", 32'(ram_raddr), 32'(0));
    chk("rst_wd", ram_wd, 32'(0));
    chk("rst_rvalid", 32'(host_rvalid), 32'(0));
    chk("rst_rdata", host_rdata, 32'(0));
    chk("rst_cnts", 32'({sb_cnt, db_cnt}), 32'(0));
    chk("rst_db_addr", 32'(db_addr), 32'(0));
    chk("rst_pulses", 32'({db_irq, scrub_pass}), 32'(0));
    host_req = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);

    // Basic host write then read.
    host_op(1'b1, 11'h123, 32'hDEADBEEF, 1'b0, 1'b0, st);
    host_op(1'b0, 11'h123, 32'hDEADBEEF, 1'b0, 1'b0, st);
    chk("idle_rd_stall", 32'(st), 32'(0));

    // Scrub corrects a single-bit error at address 5.
    host_op(1'b1, 11'h005, 32'hA5A50005, 1'b0, 1'b0, st);
    host_op(1'b1, 11'h040, 32'h12345678, 1'b0, 1'b0, st);
    host_op(1'b1, 11'h010, 32'h00001010, 1'b0, 1'b0, st);
    inject(11'h005, 1'b1, 1'b0);
    inject(11'h040, 1'b1, 1'b0);
    inject(11'h7FF, 1'b0, 1'b1);
    h = wr_total;
    scrub_en = 1'b1;
    wait_hits(11'h005, 2, 200);
    chk("wb5_data", wr_ld, 32'hA5A50005);
    chk("wb5_only_write", 32'(wr_total), 32'(h + 1));
    repeat (2) @(negedge CLK);
    chk("sb_cnt_after_5", 32'(sb_cnt), 32'(1));

    // Host write to the scrubbed word in SCRUB_CHK cancels the write-back.
    wait_rd(11'h040, 2000);
    h = wr_hits[11'h040];
    host_op(1'b1, 11'h040, 32'h0, 1'b0, 1'b0, st);
    chk("chk_cycle_stall", 32'(st), 32'(1));
    repeat (3) @(negedge CLK);
    chk("wb40_cancelled", 32'(wr_hits[11'h040]), 32'(h + 1));
    chk("sb_cnt_after_40", 32'(sb_cnt), 32'(2));
    host_op(1'b0, 11'h040, 32'h0, 1'b0, 1'b0, st);

    // Continuous host traffic holds off a pending scrub.
    inject(11'h000, 1'b1, 1'b0);
    for (i = 0; i < 3; i++) host_op(1'b0, 11'h010, 32'h00001010, 1'b0, 1'b0, st);
    sum = 0;
    for (i = 0; i < 20; i++) begin
      host_op(1'b0, 11'h010, 32'h00001010, 1'b0, 1'b0, st);
      sum += st;
    end
    chk("cont_req_stalls", 32'(sum), 32'(0));
    @(negedge CLK);
    host_op(1'b0, 11'h010, 32'h00001010, 1'b0, 1'b0, st);
    chk("gap_then_chk_gnt", 32'(st), 32'(1));

    // Double-bit error at the top of the sweep, then wrap to 0.
    for (i = 0; i < 20000; i++) begin
      if (irq_hi >= 1) break;
      @(negedge CLK);
    end
    chk("db_irq_seen", 32'(i < 20000), 32'(1));
    chk("db_addr", 32'(db_addr), 32'h7FF);
    chk("db_cnt", 32'(db_cnt), 32'(1));
    chk("pass_with_wrap", 32'(pass_hi), 32'(1));
    repeat (3) @(negedge CLK);
    chk("db_irq_width", 32'(irq_hi), 32'(1));
    chk("pass_width", 32'(pass_hi), 32'(1));
    chk("db_no_wb", 32'(wr_hits[11'h7FF]), 32'(0));
    wait_hits(11'h000, 1, 100);
    repeat (2) @(negedge CLK);
    chk("wrap_sb_cnt", 32'(sb_cnt), 32'(3));

    // Saturation and clear-with-event.
    scrub_en = 1'b0;
    repeat (4) @(negedge CLK);
    inject(11'h300, 1'b1, 1'b0);
    for (i = 0; i < 5; i++) host_op(1'b0, 11'h300, 32'h0, 1'b1, 1'b0, st);
    repeat (2) @(negedge CLK);
    chk("sb_saturated", 32'(sb_cnt), 32'(7));
    host_op(1'b0, 11'h300, 32'h0, 1'b1, 1'b0, st);
    cnt_clr = 1'b1;
    @(negedge CLK);
    cnt_clr = 1'b0;
    chk("clr_with_event_sb", 32'(sb_cnt), 32'(1));
    chk("clr_db", 32'(db_cnt), 32'(0));

    // Reset during SCRUB_WB aborts the write-back.
    host_op(1'b1, 11'h001, 32'h0BADF00D, 1'b0, 1'b0, st);
    inject(11'h001, 1'b1, 1'b0);
    RESETN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);
    chk("rst2_sb_cnt", 32'(sb_cnt), 32'(0));
    scrub_en = 1'b1;
    wait_rd(11'h001, 200);
    repeat (2) @(negedge CLK);
    chk("wb1_armed", 32'({ram_wen, ram_waddr}), 32'({1'b1, 11'h001}));
    h = wr_hits[11'h001];
    RESETN = 1'b0;
    #1;
    chk("rst_wb_wen", 32'(ram_wen), 32'(0));
    chk("rst_wb_waddr", 32'(ram_waddr), 32'(0));
    chk("rst_wb_wd", ram_wd, 32'(0));
    chk("rst_wb_cnt", 32'(sb_cnt), 32'(0));
    repeat (2) @(negedge CLK);
    chk("rst_wb_no_write", 32'(wr_hits[11'h001]), 32'(h));
    scrub_en = 1'b0;
    RESETN = 1'b1;
    @(negedge CLK);
    host_op(1'b0, 11'h001, 32'h0BADF00D, 1'b1, 1'b0, st);
    repeat (3) @(negedge CLK);
    chk("post_rst_sb_cnt", 32'(sb_cnt), 32'(1));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
